spi_pkt_slave: RTL and testbench
================================

# spi_pkt_slave

SPI mode-0 slave that exposes received RF packets to an external master. Sits directly downstream of the packet register: it captures the 64-bit `spi_data` word on each `pkt_rec` pulse into a holding register and serialises it MSB-first on `miso` during a `cs`-framed transaction. It flags pending and overrun conditions so the master can poll or react to an interrupt.

## Interface
- `PKT_W`, 64: packet width in bits; must match `spi_data`.
- `HDR_W`, 8: status header width; only used when `SPI_PKT_STATUS_HDR_EN` is defined.
- `clk`  in  1  system clock; all logic is synchronous to it.
- `rst`  in  1  asynchronous, active-low reset.
- `spi_data`  in  PKT_W  packet word from the packet register.
- `pkt_rec`  in  1  one-cycle strobe marking `spi_data` valid.
- `cs`  in  1  SPI chip select, active-low, asynchronous to `clk`.
- `sclk`  in  1  SPI clock, asynchronous to `clk`.
- `mosi`  in  1  SPI data from the master.
- `miso`  out  1  SPI data to the master.
- `pkt_ready`  out  1  level signal; a packet is held and unacknowledged.

## Operation
- `cs`, `sclk` and `mosi` each pass through a 2-flop synchroniser. Edges are detected on the synchronised `sclk` and `cs` by comparison with the previous sample.
- Holding register `hold` is loaded from `spi_data` on `pkt_rec`.
  - `pkt_rec` while `valid`=1 sets `ovf`=1.
  - Load always wins: the newest packet is kept.
- `pkt_ready` = `valid`.
- The FSM has four states: IDLE, LOAD, SHIFT and DONE.
  - IDLE: on the synchronised `cs` falling edge, go to LOAD.
  - LOAD: copy `hold` into `shadow` (under the header option, copy the header and `hold`). Clear `bitcnt`. Drive the first bit on `miso`. Go to SHIFT.
  - SHIFT: on `sclk` rising, sample `mosi`. The bit sampled at `bitcnt`=0 is latched as `ack`. On `sclk` falling, shift `shadow` left and increment `bitcnt`. When `bitcnt` reaches the frame length N, go to DONE.
  - DONE: if `ack`=1, clear `valid` and `ovf`, unless `pkt_rec` is asserted in the same cycle (then `valid` stays 1 and `ovf` clears). Return to IDLE.
- N = `PKT_W`, or `HDR_W`+`PKT_W` with the header option.
- `cs` rising before N bits: return to IDLE from any state. `valid` and `ovf` are unchanged (an aborted read counts as a peek).
- Extra `sclk` edges after N bits and before `cs` rises are ignored. `miso` is 0 during them.
- `pkt_rec` during a transaction updates `hold` only. `shadow` is frozen for the whole frame.
- `miso` is 0 in IDLE. No tri-state is used.
- Reset values:
  - `miso`=0, `pkt_ready`=0.
  - `hold`=0, `shadow`=0.
  - `valid`=0, `ovf`=0, `ack`=0.
  - `bitcnt`=0, state = IDLE.
  - Synchronisers reset to `cs`=1, `sclk`=0.
- Reset asserted mid-transaction returns the block to IDLE immediately. The master frame is lost.

## Timing
- `sclk` frequency must be ≤ `clk`/8.
- `cs` fall to first `miso` bit valid: at most 4 `clk` cycles (2 synchroniser cycles, edge detect, LOAD).
- `sclk` fall to next `miso` bit: at most 4 `clk` cycles. The master samples on `sclk` rising.
- `pkt_rec` to `pkt_ready`=1: 1 cycle.
- Final `sclk` rise to `valid`=0 (ack=1): at most 4 cycles after the corresponding fall edge is processed.
- Back-to-back `pkt_rec` strobes (every cycle) are legal. Only the last one is retained, and `ovf` is set.

## Configuration
- `SPI_PKT_STATUS_HDR_EN` defined: the frame is prefixed by an 8-bit header, MSB first.
  - Bits in order: {`valid`, `ovf`, 6-bit `pkt_cnt`}.
  - `pkt_cnt` is a 6-bit free-running count of `pkt_rec` strobes. It wraps at 63→0 and resets to 0.
  - N = 72.
- Not defined: there is no header, no `pkt_cnt` register, and N = 64.

## Structure
- Shared package `spi_pkt_pkg`:
  - FSM state encoding (IDLE/LOAD/SHIFT/DONE).
  - `PKT_W` and `HDR_W` defaults.
  - Bit-counter width of 7 bits, which covers N ≤ 72.
- Sub-module `sync2`: 2-flop synchroniser with a reset-value parameter. It is instantiated three times, for `cs`, `sclk` and `mosi`.

## Test plan
- Reset, then a packet: assert `rst`=0 → `miso`=0 and `pkt_ready`=0. Release, pulse `pkt_rec` with `spi_data`=64'hDEAD_BEEF_0123_4567 → `pkt_ready`=1 after 1 cycle.
- Full read with ack: master clocks 64 bits (72 bits with header) with `mosi` first bit=1. Master receives DEADBEEF01234567 (header 8'b10_000001 when enabled) → `pkt_ready`=0 after `cs` rises.
- Peek: same read with first `mosi` bit=0 → data is received and `pkt_ready` stays 1.
- Overrun: two `pkt_rec` strobes (packets A, then B) with no read between → a read returns B. The header `ovf` bit is 1 and `pkt_cnt`=2. An acked read clears `ovf`.
- Mid-frame update and abort:
  - `pkt_rec` with packet C at bit 20 of a read of B → the frame continues to deliver B unbroken. The next read delivers C.
  - `cs` rising at bit 30 → `valid` is unchanged and the next frame restarts from bit 0.
- Async reset at bit 40 → `miso`=0 and `pkt_ready`=0 immediately. The FSM is in IDLE and the next `cs` fall starts a clean frame.

Source files
------------

// File: rtl/spi_pkt_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkt_pkg
//
// Shared definitions for the SPI packet slave:
//   - default packet and status-header widths
//   - bit-counter width (7 bits, enough for frames up to 72 bits)
//   - FSM state encoding (IDLE / LOAD / SHIFT / DONE)
//   - frame_len(): number of bits clocked out per transaction
//
// Optional feature macro used by the design: SPI_PKT_STATUS_HDR_EN
// -----------------------------------------------------------------------------
package spi_pkt_pkg;

    localparam int PKT_W_DEF = 64;
    localparam int HDR_W_DEF = 8;
    localparam int CNT_W     = 7;
    localparam int PCNT_W    = 6;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_SHIFT = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Frame length in bits: the packet alone, or header followed by packet.
    function automatic int frame_len(input int pkt_w, input int hdr_w, input bit hdr_en);
        return hdr_en ? (pkt_w + hdr_w) : pkt_w;
    endfunction

endpackage

// File: rtl/spi_pkt_slave_sync2.sv
// -----------------------------------------------------------------------------
// sync2
//
// Two-flop synchroniser for a single asynchronous input.
//
// Parameters:
//   RST_VAL  value both flops take during reset (idle level of the input)
//
// Ports:
//   clk  in   system clock
//   rst  in   asynchronous active-low reset
//   d    in   asynchronous input
//   q    out  input synchronised to clk (2-cycle latency)
// -----------------------------------------------------------------------------
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_pkt_slave.sv
// -----------------------------------------------------------------------------
// spi_pkt_slave
//
// SPI mode-0 slave exposing the most recent received packet to an external
// master. Each pkt_rec strobe captures spi_data into a holding register; a
// cs-framed transaction shifts a frozen copy (shadow) out MSB-first on miso.
// The first mosi bit of a frame is the master's acknowledge: if it is 1 and
// the full frame is clocked, the pending (valid) and overrun (ovf) flags are
// cleared. An aborted frame (cs rising early) leaves the flags untouched.
//
// Optional feature macro: SPI_PKT_STATUS_HDR_EN
//   When defined, each frame is prefixed by an HDR_W-bit status header
//   {valid, ovf, pkt_cnt[5:0]}, where pkt_cnt counts pkt_rec strobes
//   (wrapping). When undefined, the frame is the bare packet.
//
// Parameters:
//   PKT_W  packet width (must match spi_data)
//   HDR_W  status header width (only used with the header option)
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   spi_data   in   packet word from the packet register
//   pkt_rec    in   one-cycle strobe, spi_data valid
//   cs         in   SPI chip select, active-low, asynchronous
//   sclk       in   SPI clock, asynchronous (<= clk/8)
//   mosi       in   SPI data from master
//   miso       out  SPI data to master (0 when not shifting)
//   pkt_ready  out  a packet is held and not yet acknowledged
// -----------------------------------------------------------------------------
module spi_pkt_slave
    import spi_pkt_pkg::*;
#(
    parameter int PKT_W = PKT_W_DEF,
    parameter int HDR_W = HDR_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PKT_W-1:0] spi_data,
    input  logic             pkt_rec,
    input  logic             cs,
    input  logic             sclk,
    input  logic             mosi,
    output logic             miso,
    output logic             pkt_ready
);

`ifdef SPI_PKT_STATUS_HDR_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    localparam int               FRAME_W   = frame_len(PKT_W, HDR_W, HDR_EN);
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME_W);

    // ------------------------------------------------------------------
    // Input synchronisers (idle levels: cs high, sclk low)
    // ------------------------------------------------------------------
    logic cs_s;
    logic sclk_s;
    logic mosi_s;

    sync2 #(.RST_VAL(1'b1)) u_cs_sync (
        .clk (clk),
        .rst (rst),
        .d   (cs),
        .q   (cs_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_sclk_sync (
        .clk (clk),
        .rst (rst),
        .d   (sclk),
        .q   (sclk_s)
    );

    sync2 #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk (clk),
        .rst (rst),
        .d   (mosi),
        .q   (mosi_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic               cs_prev_q,   cs_prev_d;
    logic               sclk_prev_q, sclk_prev_d;
    logic [1:0]         state_q,     state_d;
    logic [CNT_W-1:0]   bitcnt_q,    bitcnt_d;
    logic [PKT_W-1:0]   hold_q,      hold_d;
    logic [FRAME_W-1:0] shadow_q,    shadow_d;
    logic               valid_q,     valid_d;
    logic               ovf_q,       ovf_d;
    logic               ack_q,       ack_d;

    logic               cs_fall;
    logic               cs_rise;
    logic               sclk_rise;
    logic               sclk_fall;
    logic [FRAME_W-1:0] frame_word;

`ifdef SPI_PKT_STATUS_HDR_EN
    logic [PCNT_W-1:0]  pkt_cnt_q,   pkt_cnt_d;

    // Header reflects the flags as they stand when the frame is loaded.
    always_comb begin
        frame_word = {HDR_W'({valid_q, ovf_q, pkt_cnt_q}), hold_q};
    end

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_rec) begin
            pkt_cnt_d = pkt_cnt_q + PCNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q <= '0;
        end else begin
            pkt_cnt_q <= pkt_cnt_d;
        end
    end
`else
    always_comb begin
        frame_word = hold_q;
    end
`endif

    // Edge detection against the previous synchronised sample.
    always_comb begin
        cs_fall   =  cs_prev_q   & ~cs_s;
        cs_rise   = ~cs_prev_q   &  cs_s;
        sclk_rise = ~sclk_prev_q &  sclk_s;
        sclk_fall =  sclk_prev_q & ~sclk_s;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        cs_prev_d   = cs_s;
        sclk_prev_d = sclk_s;
        state_d     = state_q;
        bitcnt_d    = bitcnt_q;
        hold_d      = hold_q;
        shadow_d    = shadow_q;
        valid_d     = valid_q;
        ovf_d       = ovf_q;
        ack_d       = ack_q;

        // Packet capture runs independently of the FSM; only the shadow
        // copy is used for shifting, so a mid-frame load cannot corrupt it.
        if (pkt_rec) begin
            hold_d  = spi_data;
            valid_d = 1'b1;
            if (valid_q) begin
                ovf_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else begin
                    shadow_d = frame_word;
                    bitcnt_d = '0;
                    ack_d    = 1'b0;
                    state_d  = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (cs_rise) begin
                    // Early deselect: treated as a peek, flags untouched.
                    state_d = ST_IDLE;
                end else begin
                    if (sclk_rise && (bitcnt_q == '0)) begin
                        ack_d = mosi_s;
                    end
                    if (sclk_fall) begin
                        shadow_d = shadow_q << 1;
                        bitcnt_d = bitcnt_q + CNT_W'(1);
                        if ((bitcnt_q + CNT_W'(1)) == FRAME_CNT) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end

            ST_DONE: begin
                // A coincident pkt_rec keeps the new packet pending but the
                // overrun is still considered acknowledged.
                if (ack_q) begin
                    ovf_d = 1'b0;
                    if (!pkt_rec) begin
                        valid_d = 1'b0;
                    end
                end
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cs_prev_q   <= 1'b1;
            sclk_prev_q <= 1'b0;
            state_q     <= ST_IDLE;
            bitcnt_q    <= '0;
            hold_q      <= '0;
            shadow_q    <= '0;
            valid_q     <= 1'b0;
            ovf_q       <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            cs_prev_q   <= cs_prev_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            bitcnt_q    <= bitcnt_d;
            hold_q      <= hold_d;
            shadow_q    <= shadow_d;
            valid_q     <= valid_d;
            ovf_q       <= ovf_d;
            ack_q       <= ack_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // miso carries the shadow MSB only while shifting; the FSM leaves SHIFT
    // after the last bit, so trailing sclk edges see 0.
    assign miso      = (state_q == ST_SHIFT) ? shadow_q[FRAME_W-1] : 1'b0;
    assign pkt_ready = valid_q;

endmodule

// File: tb/tb_spi_pkt_slave.sv
// -----------------------------------------------------------------------------
// tb_spi_pkt_slave
//
// Drives packet strobes and SPI master frames into spi_pkt_slave. A reference
// model tracks the pending/overrun flags, packet count and held packet; each
// frame pushes its expected bit stream onto a queue, and an independent bus
// monitor assembles the bits seen on miso and compares them on cs rising.
// -----------------------------------------------------------------------------
module tb_spi_pkt_slave;

`ifdef SPI_PKT_STATUS_HDR_EN
    localparam int N = 72;
`else
    localparam int N = 64;
`endif
    localparam int HALF = 80;   // sclk half period in ns (clk period is 10 ns)

    logic        clk      = 1'b0;
    logic        rst      = 1'b0;
    logic [63:0] spi_data = '0;
    logic        pkt_rec  = 1'b0;
    logic        cs       = 1'b1;
    logic        sclk     = 1'b0;
    logic        mosi     = 1'b0;
    logic        miso;
    logic        pkt_ready;

    always #5 clk = ~clk;

    spi_pkt_slave dut (
        .clk       (clk),
        .rst       (rst),
        .spi_data  (spi_data),
        .pkt_rec   (pkt_rec),
        .cs        (cs),
        .sclk      (sclk),
        .mosi      (mosi),
        .miso      (miso),
        .pkt_ready (pkt_ready)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit        m_valid;
    bit        m_ovf;
    bit [5:0]  m_cnt;
    bit [63:0] m_hold;

    typedef struct {
        logic [127:0] bits;   // expected bit i of the frame at position 127-i
        int           n;      // number of sclk rises the master issues
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [127:0] model_bits();
        logic [127:0] b;
        logic [N-1:0] f;
        b = '0;
`ifdef SPI_PKT_STATUS_HDR_EN
        f = {m_valid, m_ovf, m_cnt, m_hold};
`else
        f = m_hold;
`endif
        b[127 -: N] = f;
        return b;
    endfunction

    // k consecutive pkt_rec strobes, one per clock; first word d0, rest random.
    task automatic pkts(input int k, input logic [63:0] d0);
        @(posedge clk);
        #1;
        for (int i = 0; i < k; i++) begin
            spi_data = (i == 0) ? d0 : {$urandom, $urandom};
            pkt_rec  = 1'b1;
            if (m_valid) m_ovf = 1'b1;
            m_valid = 1'b1;
            m_hold  = spi_data;
            m_cnt   = m_cnt + 6'd1;
            @(posedge clk);
            #1;
        end
        pkt_rec = 1'b0;
    endtask

    // One master transaction: nclk sclk cycles, first mosi bit = ackb.
    // pkt_at >= 0 strobes packet pd after that bit; rst_at >= 0 asserts reset
    // before that bit is clocked.
    task automatic frame(input bit ackb, input int nclk, input int pkt_at,
                         input logic [63:0] pd, input int rst_at);
        exp_t e;
        e.bits = model_bits();
        e.n    = (rst_at >= 0) ? rst_at : nclk;
        exp_q.push_back(e);

        @(posedge clk);
        #3;
        cs = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        for (int i = 0; i < nclk; i++) begin
            if (i == rst_at) begin
                rst = 1'b0;
                #1;
                check("reset_mid_miso", miso, 0);
                check("reset_mid_pkt_ready", pkt_ready, 0);
                m_valid = 1'b0;
                m_ovf   = 1'b0;
                m_cnt   = '0;
                m_hold  = '0;
                break;
            end
            mosi = (i == 0) ? ackb : 1'($urandom);
            #(HALF);
            sclk = 1'b1;
            #(HALF);
            sclk = 1'b0;
            if (i == pkt_at) begin
                pkts(1, pd);
                @(posedge clk);
                #3;
            end
        end
        #(HALF);
        cs   = 1'b1;
        mosi = 1'b0;
        if (rst_at >= 0) begin
            repeat (3) @(posedge clk);
            #3;
            rst = 1'b1;
        end
        repeat (8) @(posedge clk);
        #3;
        if (rst_at < 0 && nclk >= N && ackb) begin
            m_valid = 1'b0;
            m_ovf   = 1'b0;
        end
        check("pkt_ready_after_frame", pkt_ready, m_valid);
    endtask

    // Bus monitor: samples miso on each sclk rise inside a cs-low window.
    initial begin
        forever begin
            logic [127:0] act;
            logic [127:0] mask;
            int           cnt;
            exp_t         e;
            @(negedge cs);
            act = '0;
            cnt = 0;
            forever begin
                @(posedge sclk or posedge cs);
                if (cs) break;
                if (cnt < 128) act[127-cnt] = miso;
                cnt++;
            end
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got a frame of %0d bits, expected none", cnt);
            end else begin
                e = exp_q.pop_front();
                check("frame_bitcount", cnt, e.n);
                mask = '0;
                for (int i = 0; i < e.n && i < 128; i++) mask[127-i] = 1'b1;
                check("frame_data", act & mask, e.bits & mask);
            end
        end
    end

    initial begin
        int k;
        int sel;
        int nclk;
        int lim;
        int pat;
        bit ab;

        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_cnt   = '0;
        m_hold  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #3;
        check("reset_miso", miso, 0);
        check("reset_pkt_ready", pkt_ready, 0);
        rst = 1'b1;
        repeat (3) @(posedge clk);

        // First packet; pending one cycle after the strobe
        pkts(1, 64'hDEAD_BEEF_0123_4567);
        check("pkt_ready_1cyc", pkt_ready, 1);

        // Full acked read, with trailing sclk edges that must read as 0
        frame(1'b1, N + 3, -1, '0, -1);

        // Peek: no ack, packet stays pending
        pkts(1, 64'hDEAD_BEEF_0123_4567);
        frame(1'b0, N, -1, '0, -1);

        // Overrun: A then B, read returns B with ovf set; ack clears it
        pkts(1, 64'hAAAA_0000_1111_2222);
        pkts(1, 64'hBBBB_3333_4444_5555);
        frame(1'b0, N, -1, '0, -1);
        frame(1'b1, N, -1, '0, -1);
        frame(1'b0, N, -1, '0, -1);

        // Mid-frame update: B is delivered intact, next read delivers C
        pkts(1, 64'hBBBB_3333_4444_5555);
        frame(1'b0, N, 20, 64'hCCCC_6666_7777_8888, -1);
        frame(1'b0, N, -1, '0, -1);

        // Abort at bit 30 with ack: flags unchanged, next frame restarts
        frame(1'b1, 30, -1, '0, -1);
        frame(1'b1, N, -1, '0, -1);

        // Back-to-back strobes every cycle
        pkts(6, 64'h0123_4567_89AB_CDEF);
        frame(1'b0, N, -1, '0, -1);

        // Async reset at bit 40, then a clean frame
        pkts(1, 64'hFEDC_BA98_7654_3210);
        frame(1'b1, N, -1, '0, 40);
        pkts(1, 64'h1357_9BDF_2468_ACE0);
        frame(1'b1, N, -1, '0, -1);

        // Randomised traffic
        for (int it = 0; it < 12; it++) begin
            k = $urandom_range(0, 3);
            if (k > 0) pkts(k, {$urandom, $urandom});
            sel = $urandom_range(0, 2);
            if (sel == 0)      nclk = $urandom_range(1, N - 1);
            else if (sel == 1) nclk = N;
            else               nclk = N + $urandom_range(1, 4);
            lim = (nclk < N) ? nclk : N;
            pat = -1;
            if (lim >= 4 && $urandom_range(0, 2) == 0) pat = $urandom_range(0, lim - 3);
            ab = 1'($urandom);
            frame(ab, nclk, pat, {$urandom, $urandom}, -1);
        end

        repeat (10) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
